// File: rtl/burst_ram_pkg.sv
// Shared opcode and FSM state encodings for the burst RAM controller.
package burst_ram_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/burst_ram_array.sv
// DATA_W x DEPTH register file: synchronous write, combinational read,
// whole array zeroed while rst_n is low at a clock edge.
module burst_ram_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned ADDR_X_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = ADDR_X_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              raddr_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range addresses only occur for non-power-of-two DEPTH; read 0.
    assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);
    assign rdata    = raddr_ok ? mem[raddr] : '0;

endmodule

// File: rtl/burst_ram_ctrl.sv
// Command FSM in front of a register-file RAM: burst write, burst read with
// address wrap, and whole-array clear, all with valid/ready beat handshakes.
module burst_ram_ctrl
    import burst_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam logic [1:0] S_READ  = READ;
    localparam logic [1:0] S_CLEAR = CLEAR;

    localparam int unsigned     ADDR_X_W  = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = ADDR_X_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt, ptr_inc;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] rd_data_nxt;
    logic              rd_valid_nxt, done_nxt, err_nxt;
    logic              addr_bad;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    burst_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wr_ready  = (state == S_WRITE);

    assign ptr_inc  = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
    assign addr_bad = ({1'b0, cmd_addr} >= DEPTH_EXT);

    // Read port looks at the start address when idle, else the next beat.
    assign mem_raddr = (state == S_IDLE) ? cmd_addr : ptr_inc;
    assign mem_waddr = ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            rd_data  <= rd_data_nxt;
            rd_valid <= rd_valid_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = rd_valid;
        done_nxt     = 1'b0;
        err_nxt      = err;
        mem_we       = 1'b0;
        mem_wdata    = wr_data;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    ptr_nxt = cmd_addr;
                    cnt_nxt = cmd_len;
                    case (cmd_op)
                        OP_WRITE: begin
                            if (addr_bad) err_nxt = 1'b1;
                            else          state_nxt = S_WRITE;
                        end
                        OP_READ: begin
                            if (addr_bad) begin
                                err_nxt = 1'b1;
                            end else begin
                                state_nxt    = S_READ;
                                rd_valid_nxt = 1'b1;
                                rd_data_nxt  = mem_rdata;
                            end
                        end
                        OP_CLEAR: begin
                            ptr_nxt   = '0;
                            state_nxt = S_CLEAR;
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
            end

            S_WRITE: begin
                if (wr_valid) begin
                    mem_we  = 1'b1;
                    ptr_nxt = ptr_inc;
                    if (cnt == '0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - ADDR_W'(1);
                    end
                end
            end

            S_READ: begin
                if (rd_valid && rd_ready) begin
                    if (cnt != '0) begin
                        ptr_nxt     = ptr_inc;
                        cnt_nxt     = cnt - ADDR_W'(1);
                        rd_data_nxt = mem_rdata;
                    end else begin
                        rd_valid_nxt = 1'b0;
                        state_nxt    = S_IDLE;
                        done_nxt     = 1'b1;
                    end
                end
            end

            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                ptr_nxt   = ptr_inc;
                if (ptr == LAST_ADDR) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_burst_ram_ctrl.sv
// Directed self-checking bench for burst_ram_ctrl (DEPTH=16 and DEPTH=10).
module tb_burst_ram_ctrl;
    import burst_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid, cmd_ready, wr_valid, wr_ready, rd_valid, rd_ready;
    logic       busy, done, err;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr, cmd_len;
    logic [7:0] wr_data, rd_data;

    logic       b_cmd_valid, b_cmd_ready, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
    logic       b_busy, b_done, b_err;
    logic [1:0] b_cmd_op;
    logic [3:0] b_cmd_addr, b_cmd_len;
    logic [7:0] b_wr_data, b_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] wbuf [$];
    logic [7:0] rbuf [$];
    int         done_cnt, cyc_cnt, stall_viol;
    logic       first_valid;

    burst_ram_ctrl #(.DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .err(err)
    );

    burst_ram_ctrl #(.DATA_W(8), .DEPTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len),
        .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Called at a negedge while idle; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] l);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] a, input logic [3:0] l, input logic gaps);
        int i = 0;
        done_cnt = 0; cyc_cnt = 0;
        send_cmd(OP_WRITE, a, l);
        for (int c = 0; c < 64; c++) begin
            if (gaps && c[0]) begin
                wr_valid = 1'b0; wr_data = 8'hEE;
            end else begin
                wr_valid = 1'b1;
                wr_data  = (i < wbuf.size()) ? wbuf[i] : 8'h00;
                i++;
            end
            @(negedge clk);
            cyc_cnt++;
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b1) break;
        end
        wr_valid = 1'b0;
        repeat (2) begin @(negedge clk); if (done === 1'b1) done_cnt++; end
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input logic toggle);
        logic       stalled = 1'b0;
        logic [7:0] held = 8'h00;
        rbuf.delete(); done_cnt = 0; cyc_cnt = 0; stall_viol = 0;
        send_cmd(OP_READ, a, l);
        first_valid = rd_valid;
        for (int c = 0; c < 64; c++) begin
            if (stalled && (rd_valid !== 1'b1 || rd_data !== held)) stall_viol++;
            rd_ready = toggle ? c[0] : 1'b1;
            stalled  = rd_valid && !rd_ready;
            held     = rd_data;
            if (rd_valid === 1'b1 && rd_ready) rbuf.push_back(rd_data);
            @(negedge clk);
            cyc_cnt++;
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b1) break;
        end
        rd_ready = 1'b0;
        repeat (2) begin @(negedge clk); if (done === 1'b1) done_cnt++; end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL reset_idle: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin failures++;
            $display("FAIL reset_rd: rd_valid=%b rd_data=%h expected 0/00", rd_valid, rd_data); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++;
            $display("FAIL reset_flags: done=%b err=%b expected 0/0", done, err); end
        read_burst(4'd0, 4'd15, 1'b0);
        foreach (rbuf[k]) if (rbuf[k] !== 8'h00) bad++;
        checks++; if (rbuf.size() != 16 || bad != 0) begin failures++;
            $display("FAIL reset_ram: beats=%0d nonzero=%0d expected 16/0", rbuf.size(), bad); end
        checks++; if (done_cnt != 1 || err !== 1'b0) begin failures++;
            $display("FAIL reset_read_done: done_cnt=%0d err=%b expected 1/0", done_cnt, err); end
    endtask

    task automatic test_write_read();
        logic [31:0] got = 32'h0;
        wbuf = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        write_burst(4'd3, 4'd3, 1'b0);
        checks++; if (done_cnt != 1 || cyc_cnt != 4) begin failures++;
            $display("FAIL wr_done: done_cnt=%0d cycles=%0d expected 1/4", done_cnt, cyc_cnt); end
        read_burst(4'd3, 4'd3, 1'b0);
        if (rbuf.size() == 4) got = {rbuf[0], rbuf[1], rbuf[2], rbuf[3]};
        checks++; if (got !== 32'hA1B2C3D4) begin failures++;
            $display("FAIL rd_data_seq: got %h expected a1b2c3d4 (beats=%0d)", got, rbuf.size()); end
        checks++; if (first_valid !== 1'b1 || cyc_cnt != 4 || done_cnt != 1) begin failures++;
            $display("FAIL rd_timing: first_valid=%b cycles=%0d done_cnt=%0d expected 1/4/1",
                     first_valid, cyc_cnt, done_cnt); end
    endtask

    task automatic test_wrap();
        logic [31:0] got = 32'h0;
        wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_burst(4'd14, 4'd3, 1'b0);
        read_burst(4'd14, 4'd3, 1'b0);
        if (rbuf.size() == 4) got = {rbuf[0], rbuf[1], rbuf[2], rbuf[3]};
        checks++; if (got !== 32'h11223344) begin failures++;
            $display("FAIL wrap16_seq: got %h expected 11223344", got); end
        got = 32'h0;
        read_burst(4'd0, 4'd1, 1'b0);
        if (rbuf.size() == 2) got = {16'h0, rbuf[0], rbuf[1]};
        checks++; if (got !== 32'h00003344) begin failures++;
            $display("FAIL wrap16_low: got %h expected 00003344", got); end
    endtask

    task automatic test_depth10();
        logic [23:0] got = 24'h0;
        logic [7:0]  q [$];
        b_cmd_valid = 1'b1; b_cmd_op = OP_WRITE; b_cmd_addr = 4'd8; b_cmd_len = 4'd3;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_wr_valid = 1'b1; b_wr_data = 8'h81 + 8'(i);
            @(negedge clk);
        end
        b_wr_valid = 1'b0;
        checks++; if (b_done !== 1'b1 || b_busy !== 1'b0) begin failures++;
            $display("FAIL d10_wr_done: done=%b busy=%b expected 1/0", b_done, b_busy); end
        b_cmd_valid = 1'b1; b_cmd_op = OP_READ; b_cmd_addr = 4'd9; b_cmd_len = 4'd2;
        b_rd_ready = 1'b1;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (b_busy !== 1'b1) break;
            if (b_rd_valid === 1'b1) q.push_back(b_rd_data);
            @(negedge clk);
        end
        b_rd_ready = 1'b0;
        if (q.size() == 3) got = {q[0], q[1], q[2]};
        checks++; if (got !== 24'h828384) begin failures++;
            $display("FAIL d10_wrap_seq: got %h expected 828384 (beats=%0d)", got, q.size()); end
        checks++; if (b_err !== 1'b0) begin failures++;
            $display("FAIL d10_err_pre: err=%b expected 0", b_err); end
        b_cmd_valid = 1'b1; b_cmd_op = OP_WRITE; b_cmd_addr = 4'd12; b_cmd_len = 4'd0;
        b_wr_valid = 1'b1; b_wr_data = 8'h99;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        checks++; if (b_err !== 1'b1 || b_busy !== 1'b0 || b_wr_ready !== 1'b0) begin failures++;
            $display("FAIL d10_bad_addr: err=%b busy=%b wr_ready=%b expected 1/0/0",
                     b_err, b_busy, b_wr_ready); end
        b_wr_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [23:0] got = 24'h0;
        wbuf = '{8'h5A, 8'h6B, 8'h7C};
        write_burst(4'd6, 4'd2, 1'b1);
        checks++; if (cyc_cnt != 5 || done_cnt != 1) begin failures++;
            $display("FAIL wr_gaps: cycles=%0d done_cnt=%0d expected 5/1", cyc_cnt, done_cnt); end
        read_burst(4'd6, 4'd2, 1'b1);
        if (rbuf.size() == 3) got = {rbuf[0], rbuf[1], rbuf[2]};
        checks++; if (got !== 24'h5A6B7C) begin failures++;
            $display("FAIL bp_seq: got %h expected 5a6b7c (beats=%0d)", got, rbuf.size()); end
        checks++; if (stall_viol != 0 || done_cnt != 1) begin failures++;
            $display("FAIL bp_stall: unstable=%0d done_cnt=%0d expected 0/1", stall_viol, done_cnt); end
        read_burst(4'd9, 4'd0, 1'b0);
        checks++; if (rbuf.size() != 1 || rbuf[0] !== 8'h00) begin failures++;
            $display("FAIL wr_gap_spurious: beats=%0d data=%h expected 1/00",
                     rbuf.size(), (rbuf.size() > 0) ? rbuf[0] : 8'hxx); end
    endtask

    task automatic test_clear_rsvd();
        int bad = 0;
        int rdv = 0;
        int nrdy = 0;
        wbuf.delete();
        for (int i = 0; i < 16; i++) wbuf.push_back(8'hFF);
        write_burst(4'd5, 4'd15, 1'b0);
        read_burst(4'd0, 4'd15, 1'b0);
        foreach (rbuf[k]) if (rbuf[k] !== 8'hFF) bad++;
        checks++; if (rbuf.size() != 16 || bad != 0) begin failures++;
            $display("FAIL fill_ff: beats=%0d wrong=%0d expected 16/0", rbuf.size(), bad); end
        send_cmd(OP_CLEAR, 4'd7, 4'd3);
        cyc_cnt = 0;
        for (int c = 0; c < 64; c++) begin
            if (busy !== 1'b1) break;
            cmd_valid = (c < 3); cmd_op = OP_READ; cmd_addr = 4'd0; cmd_len = 4'd0;
            if (cmd_ready !== 1'b0) nrdy++;
            if (rd_valid !== 1'b0) rdv++;
            cyc_cnt++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++; if (cyc_cnt != 16 || done !== 1'b1) begin failures++;
            $display("FAIL clear_busy: busy_cycles=%0d done=%b expected 16/1", cyc_cnt, done); end
        checks++; if (nrdy != 0 || rdv != 0) begin failures++;
            $display("FAIL busy_cmd_ignored: cmd_ready_high=%0d rd_valid_high=%0d expected 0/0",
                     nrdy, rdv); end
        read_burst(4'd0, 4'd15, 1'b0);
        bad = 0;
        foreach (rbuf[k]) if (rbuf[k] !== 8'h00) bad++;
        checks++; if (rbuf.size() != 16 || bad != 0) begin failures++;
            $display("FAIL clear_ram: beats=%0d nonzero=%0d expected 16/0", rbuf.size(), bad); end
        checks++; if (err !== 1'b0) begin failures++;
            $display("FAIL err_pre_rsvd: err=%b expected 0", err); end
        send_cmd(OP_RSVD, 4'd0, 4'd0);
        checks++; if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL rsvd: err=%b busy=%b cmd_ready=%b done=%b expected 1/0/1/0",
                     err, busy, cmd_ready, done); end
        read_burst(4'd0, 4'd0, 1'b0);
        checks++; if (err !== 1'b1 || done_cnt != 1) begin failures++;
            $display("FAIL err_sticky: err=%b done_cnt=%0d expected 1/1", err, done_cnt); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int dn = 0;
        send_cmd(OP_WRITE, 4'd0, 4'd7);
        wr_valid = 1'b1; wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22; rst_n = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0; rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: busy=%b rd_valid=%b done=%b err=%b expected 0/0/0/0",
                     busy, rd_valid, done, err); end
        repeat (3) begin @(negedge clk); if (done === 1'b1) dn++; end
        checks++; if (dn != 0 || busy !== 1'b0) begin failures++;
            $display("FAIL mid_reset_no_done: done_pulses=%0d busy=%b expected 0/0", dn, busy); end
        read_burst(4'd0, 4'd15, 1'b0);
        foreach (rbuf[k]) if (rbuf[k] !== 8'h00) bad++;
        checks++; if (rbuf.size() != 16 || bad != 0) begin failures++;
            $display("FAIL mid_reset_ram: beats=%0d nonzero=%0d expected 16/0", rbuf.size(), bad); end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'd0; cmd_len = 4'd0;
        wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_addr = 4'd0; b_cmd_len = 4'd0;
        b_wr_valid = 1'b0; b_wr_data = 8'h00; b_rd_ready = 1'b0;
        test_reset();
        test_write_read();
        test_wrap();
        test_depth10();
        test_backpressure();
        test_clear_rsvd();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
